// File: rtl/dec_bit_unloader_pkg.sv
// Shared definitions for the decoder frame stores: code decode, frame/word
// sizes and the unloader FSM state encoding.
package dec_bit_unloader_pkg;

    localparam int MAX_N  = 1024;
    localparam int WORD_W = 64;
    localparam int LANES  = 4;
    localparam int POS_W  = 10;
    localparam int LEN_W  = POS_W + 1;
    localparam int WIDX_W = 4;

    localparam logic [1:0] CODE_128  = 2'd0;
    localparam logic [1:0] CODE_256  = 2'd1;
    localparam logic [1:0] CODE_1024 = 2'd2;

    localparam logic [LEN_W-1:0] N_128  = 11'd128;
    localparam logic [LEN_W-1:0] N_256  = 11'd256;
    localparam logic [LEN_W-1:0] N_1024 = 11'd1024;

    localparam int WORDS_128  = 128 / WORD_W;
    localparam int WORDS_256  = 256 / WORD_W;
    localparam int WORDS_1024 = 1024 / WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Code 3 is reserved and falls back to the shortest frame.
    function automatic logic [LEN_W-1:0] code_to_len(input logic [1:0] code);
        case (code)
            CODE_256:  return N_256;
            CODE_1024: return N_1024;
            default:   return N_128;
        endcase
    endfunction

    function automatic logic [WIDX_W-1:0] code_to_last_word(input logic [1:0] code);
        case (code)
            CODE_256:  return WIDX_W'(WORDS_256 - 1);
            CODE_1024: return WIDX_W'(WORDS_1024 - 1);
            default:   return WIDX_W'(WORDS_128 - 1);
        endcase
    endfunction

endpackage

// File: rtl/dec_bit_word_mux.sv
// Combinational selection of one 64-bit slice of the frame buffer.
module dec_bit_word_mux
    import dec_bit_unloader_pkg::*;
(
    input  logic [MAX_N-1:0]  frame_bits,
    input  logic [WIDX_W-1:0] word_idx,
    output logic [WORD_W-1:0] word
);

    assign word = frame_bits[{word_idx, 6'd0} +: WORD_W];

endmodule

// File: rtl/dec_bit_unloader.sv
// Collects decoder hard decisions into a frame buffer, then streams the frame
// out as 64-bit words over a valid/ready handshake.
module dec_bit_unloader
    import dec_bit_unloader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_code,
    input  logic              i_start,
    input  logic [LANES-1:0]  i_wen,
    input  logic [POS_W-1:0]  i_pos0,
    input  logic [POS_W-1:0]  i_pos1,
    input  logic [POS_W-1:0]  i_pos2,
    input  logic [POS_W-1:0]  i_pos3,
    input  logic [LANES-1:0]  i_bit,
    input  logic              i_done,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_frame_done
);

    state_t              state;
    logic [MAX_N-1:0]    frame_q;
    logic [MAX_N-1:0]    frame_next;
    logic [LEN_W-1:0]    frame_len;
    logic [WIDX_W-1:0]   word_cnt;
    logic [WIDX_W-1:0]   last_word;
    logic [WIDX_W-1:0]   mux_idx;
    logic [WORD_W-1:0]   mux_word;
    logic [POS_W-1:0]    lane_pos [LANES];

    assign lane_pos[0] = i_pos0;
    assign lane_pos[1] = i_pos1;
    assign lane_pos[2] = i_pos2;
    assign lane_pos[3] = i_pos3;

    // Ascending lane order lets the highest lane win on a position collision.
    always_comb begin
        frame_next = frame_q;
        if (state == ST_IDLE && i_start) begin
            frame_next = '0;
        end else if (state == ST_COLLECT) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wen[k] && ({1'b0, lane_pos[k]} < frame_len)) begin
                    frame_next[lane_pos[k]] = i_bit[k];
                end
            end
        end
    end

    // The mux looks at the next buffer state so that word 0 already carries
    // writes committed in the i_done cycle; in DRAIN it prefetches word_cnt+1.
    assign mux_idx = (state == ST_DRAIN) ? word_cnt + WIDX_W'(1) : '0;

    dec_bit_word_mux u_word_mux (
        .frame_bits (frame_next),
        .word_idx   (mux_idx),
        .word       (mux_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            frame_q      <= '0;
            frame_len    <= '0;
            word_cnt     <= '0;
            last_word    <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_last       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            frame_q      <= frame_next;
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_COLLECT;
                        frame_len <= code_to_len(i_code);
                        last_word <= code_to_last_word(i_code);
                        word_cnt  <= '0;
                        o_busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (i_done) begin
                        state    <= ST_DRAIN;
                        word_cnt <= '0;
                        o_valid  <= 1'b1;
                        o_data   <= mux_word;
                        o_last   <= (last_word == '0);
                    end
                end
                ST_DRAIN: begin
                    if (i_ready) begin
                        if (word_cnt == last_word) begin
                            state        <= ST_IDLE;
                            o_valid      <= 1'b0;
                            o_last       <= 1'b0;
                            o_busy       <= 1'b0;
                            o_frame_done <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + WIDX_W'(1);
                            o_data   <= mux_word;
                            o_last   <= (word_cnt + WIDX_W'(1) == last_word);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bit_unloader.sv
// Self-checking bench for dec_bit_unloader: table-driven single-write frames
// plus hand-written multi-cycle scenarios, words checked through a scoreboard.
module tb_dec_bit_unloader;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_word_t;

    typedef struct {
        logic [1:0] code;
        logic [9:0] pos;
        logic       bitv;
        int         nwords;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_code;
    logic        i_start;
    logic [3:0]  i_wen;
    logic [9:0]  i_pos0, i_pos1, i_pos2, i_pos3;
    logic [3:0]  i_bit;
    logic        i_done;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_data;
    logic        o_last;
    logic        o_busy;
    logic        o_frame_done;

    exp_word_t   sb[$];
    vec_t        vecs[10];
    int          compared   = 0;
    int          mismatched = 0;
    int          rx_count   = 0;
    logic [1023:0] model;
    int          model_len;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    dec_bit_unloader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_code       (i_code),
        .i_start      (i_start),
        .i_wen        (i_wen),
        .i_pos0       (i_pos0),
        .i_pos1       (i_pos1),
        .i_pos2       (i_pos2),
        .i_pos3       (i_pos3),
        .i_bit        (i_bit),
        .i_done       (i_done),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int codeLen(input logic [1:0] code);
        case (code)
            2'd1:    return 256;
            2'd2:    return 1024;
            default: return 128;
        endcase
    endfunction

    task automatic startFrame(input logic [1:0] code);
        i_code  = code;
        i_start = 1'b1;
        tick();
        i_start   = 1'b0;
        model     = '0;
        model_len = codeLen(code);
        rx_count  = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] wen, input logic [9:0] p0, input logic [9:0] p1,
                                 input logic [9:0] p2, input logic [9:0] p3, input logic [3:0] bits,
                                 input bit update_model);
        logic [9:0] p[4];
        p = '{p0, p1, p2, p3};
        i_wen  = wen;
        i_pos0 = p0;
        i_pos1 = p1;
        i_pos2 = p2;
        i_pos3 = p3;
        i_bit  = bits;
        tick();
        i_wen = '0;
        if (update_model) begin
            for (int k = 0; k < 4; k++) begin
                if (wen[k] && int'(p[k]) < model_len) model[p[k]] = bits[k];
            end
        end
    endtask

    task automatic randomWrites(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(4'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
                          10'($urandom), 4'($urandom), 1'b1);
        end
    endtask

    task automatic pushExp(input logic [63:0] data, input logic last);
        exp_word_t e;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic finishFrame(input bit push_model);
        if (push_model) begin
            for (int w = 0; w < model_len / 64; w++) begin
                pushExp(model[w*64 +: 64], (w == model_len / 64 - 1));
            end
        end
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
    endtask

    task automatic waitFrameDone(input int maxc);
        bit found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (o_frame_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("frame_done_seen", 64'(found), 64'd1);
    endtask

    task automatic checkIdleAfter();
        checkOutput("done_valid", 64'(o_valid), 64'd0);
        checkOutput("done_last", 64'(o_last), 64'd0);
        checkOutput("done_busy", 64'(o_busy), 64'd0);
        tick();
        checkOutput("done_pulse_width", 64'(o_frame_done), 64'd0);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard side: every handshake pops one expected word, and a stalled
    // word must not change until it is accepted.
    always @(negedge i_clk) begin
        exp_word_t e;
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_valid) begin
                checkOutput("stall_data", o_data, prev_data);
                checkOutput("stall_last", 64'(o_last), 64'(prev_last));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got %h expected none", o_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("word_data", o_data, e.data);
                    checkOutput("word_last", 64'(o_last), 64'(e.last));
                end
                rx_count++;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    initial begin
        vecs[0] = '{2'd0, 10'd0,    1'b1, 2};
        vecs[1] = '{2'd0, 10'd127,  1'b1, 2};
        vecs[2] = '{2'd0, 10'd128,  1'b1, 2};
        vecs[3] = '{2'd1, 10'd255,  1'b1, 4};
        vecs[4] = '{2'd1, 10'd256,  1'b1, 4};
        vecs[5] = '{2'd2, 10'd64,   1'b1, 16};
        vecs[6] = '{2'd2, 10'd1023, 1'b1, 16};
        vecs[7] = '{2'd3, 10'd63,   1'b1, 2};
        vecs[8] = '{2'd3, 10'd200,  1'b1, 2};
        vecs[9] = '{2'd1, 10'd130,  1'b0, 4};

        i_rst = 1'b1; i_code = '0; i_start = 1'b0; i_wen = '0; i_bit = '0; i_done = 1'b0;
        i_pos0 = '0; i_pos1 = '0; i_pos2 = '0; i_pos3 = '0; i_ready = 1'b1;
        model = '0; model_len = 128;
        tick();
        tick();
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_data", o_data, 64'd0);
        checkOutput("rst_last", 64'(o_last), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_frame_done", 64'(o_frame_done), 64'd0);
        i_rst = 1'b0;
        tick();

        $display("[TB] idle ignores writes and done");
        i_done = 1'b1;
        applyStimulus(4'hF, 10'd1, 10'd2, 10'd3, 10'd4, 4'hF, 1'b0);
        i_done = 1'b0;
        tick();
        checkOutput("idle_valid", 64'(o_valid), 64'd0);
        checkOutput("idle_busy", 64'(o_busy), 64'd0);

        $display("[TB] alternating pattern, code 0");
        startFrame(2'd0);
        checkOutput("start_busy", 64'(o_busy), 64'd1);
        for (int c = 0; c < 32; c++) begin
            applyStimulus(4'hF, 10'(4*c), 10'(4*c+1), 10'(4*c+2), 10'(4*c+3), 4'b1010, 1'b1);
        end
        pushExp(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        pushExp(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
        finishFrame(1'b0);
        checkOutput("latency_valid", 64'(o_valid), 64'd1);
        checkOutput("latency_data", o_data, 64'hAAAA_AAAA_AAAA_AAAA);
        waitFrameDone(20);
        checkOutput("t1_words", 64'(rx_count), 64'd2);
        checkOutput("t1_data_hold", o_data, 64'hAAAA_AAAA_AAAA_AAAA);
        checkIdleAfter();

        $display("[TB] single top bit, code 2");
        startFrame(2'd2);
        applyStimulus(4'b0001, 10'd1023, 10'd0, 10'd0, 10'd0, 4'b0001, 1'b1);
        for (int w = 0; w < 15; w++) pushExp(64'd0, 1'b0);
        pushExp(64'h8000_0000_0000_0000, 1'b1);
        finishFrame(1'b0);
        waitFrameDone(40);
        checkOutput("t2_words", 64'(rx_count), 64'd16);
        checkIdleAfter();

        $display("[TB] lane collision and out-of-range write, code 1");
        startFrame(2'd1);
        applyStimulus(4'b1011, 10'd5, 10'd300, 10'd0, 10'd5, 4'b1010, 1'b1);
        pushExp(64'h20, 1'b0);
        pushExp(64'd0, 1'b0);
        pushExp(64'd0, 1'b0);
        pushExp(64'd0, 1'b1);
        finishFrame(1'b0);
        waitFrameDone(20);
        checkOutput("t3_words", 64'(rx_count), 64'd4);
        checkIdleAfter();

        $display("[TB] backpressure 1,0,0,1");
        startFrame(2'd1);
        randomWrites(20);
        i_ready = 1'b1;
        finishFrame(1'b1);
        tick();
        i_ready = 1'b0;
        tick();
        tick();
        checkOutput("stall_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b1;
        waitFrameDone(20);
        checkOutput("t4_words", 64'(rx_count), 64'd4);
        checkIdleAfter();

        $display("[TB] reset mid-drain");
        startFrame(2'd2);
        randomWrites(10);
        finishFrame(1'b1);
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("mid_rst_valid", 64'(o_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(o_busy), 64'd0);
        checkOutput("mid_rst_last", 64'(o_last), 64'd0);
        checkOutput("mid_rst_words", 64'(rx_count), 64'd2);
        sb.delete();
        startFrame(2'd0);
        randomWrites(12);
        finishFrame(1'b1);
        waitFrameDone(20);
        checkOutput("t5_words", 64'(rx_count), 64'd2);
        checkIdleAfter();

        $display("[TB] start ignored in drain, restart on frame_done");
        startFrame(2'd1);
        randomWrites(16);
        i_ready = 1'b0;
        finishFrame(1'b1);
        tick();
        i_code  = 2'd2;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        applyStimulus(4'hF, 10'd0, 10'd1, 10'd2, 10'd3, 4'hF, 1'b0);
        checkOutput("drain_start_busy", 64'(o_busy), 64'd1);
        checkOutput("drain_start_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b1;
        waitFrameDone(20);
        checkOutput("t6_words", 64'(rx_count), 64'd4);
        startFrame(2'd0);
        checkOutput("restart_busy", 64'(o_busy), 64'd1);
        finishFrame(1'b1);
        waitFrameDone(20);
        checkOutput("t6b_words", 64'(rx_count), 64'd2);
        checkIdleAfter();

        $display("[TB] table vectors");
        for (int v = 0; v < 10; v++) begin
            startFrame(vecs[v].code);
            applyStimulus(4'b0100, 10'd0, 10'd0, vecs[v].pos, 10'd0,
                          {1'b0, vecs[v].bitv, 2'b00}, 1'b1);
            finishFrame(1'b1);
            waitFrameDone(40);
            checkOutput($sformatf("vec%0d_words", v), 64'(rx_count), 64'(vecs[v].nwords));
            checkIdleAfter();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
